// File: rtl/mem_access_seq.sv
// mem_access_seq: single-outstanding load/store sequencer between a byte-addressed
// request port and a 32-bit word memory.
//   - Loads read the containing word for MEM_LAT cycles, then extract and
//     zero/sign-extend the addressed byte/half.
//   - Word stores write in one cycle.
//   - Sub-word stores read-modify-write the containing word.
//   - Misaligned or reserved-size requests complete immediately with rsp_err.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             request handshake (valid/ready) and fields; sampled on accept only
//   mem_*             word-aligned memory port (rd/wr strobes, addr, wdata, rdata)
//   rsp_valid/rdata/err  one-cycle completion pulse with load data / error flag
module mem_access_seq #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_bad;

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (sz)
      2'd0:    return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed lane of the read word with the right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (sz == 2'd0)      r[{off, 3'b000} +: 8]     = wd[7:0];
    else if (sz == 2'd1) r[{off[1], 4'b0000} +: 16] = wd[15:0];
    else                 r = wd;
    return r;
  endfunction

  assign req_bad = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    size_d      = size_q;
    sign_d      = sign_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    // strobes are pulses; ready tracks "next state is IDLE"
    ready_d     = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          sign_d     = req_sign;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata;
          mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          if (req_bad) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else if (req_write && req_size == 2'd2) begin
            state_d     = S_WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            // loads and sub-word stores both start with a read
            state_d  = S_RD;
            mem_rd_d = 1'b1;
            cnt_d    = LAT_M1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          // last read cycle: mem_rdata is valid at this edge
          if (write_q) begin
            state_d     = S_WR;
            mem_wr_d    = 1'b1;
            mem_wdata_d = lane_merge(mem_rdata, size_q, off_q, wdata_q);
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lane_extract(mem_rdata, size_q, sign_q, off_q);
          end
        end else begin
          cnt_d    = cnt_q - 4'd1;
          mem_rd_d = 1'b1;
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      off_q       <= 2'd0;
      wdata_q     <= 32'h0;
      ready_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq (ADDR_W=32, MEM_LAT=2). A transaction-level model
// turns each accepted request into a timeline (read cycles, write cycle and
// data, response cycle and data) relative to the accept edge; a negedge
// process compares every output against that timeline each cycle. A sparse
// word memory backs the DUT and only presents valid data in the last read cycle.
module tb_mem_access_seq;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_sign = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  mem_access_seq #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory + transaction model ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input int sz, input bit sg, input int off);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input int sz, input int off, input logic [31:0] wd);
    logic [31:0] m;
    if (sz == 0) m = 32'hFF << (8 * off);
    else if (sz == 1) m = 32'hFFFF << (16 * (off / 2));
    else m = 32'hFFFFFFFF;
    return (w & ~m) | ((wd << (8 * off)) & m);
  endfunction

  bit          started = 0;
  bit          txn = 0;
  int          cyc = 0, acc = 0, prev_acc = 0, acc_cnt = 0;
  int          rd_n = 0, wr_d = 0, rsp_d = 0, rd_run = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0, last_rdata = 0;
  bit          e_err = 0;
  int          wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
  logic [31:0] last_wr_data = 0, last_wr_addr = 0, last_rsp_rdata = 0;
  int          last_wr_d = 0, last_rsp_d = 0;
  bit          last_rsp_err = 0;

  function automatic bit model_ready();
    return !txn || ((cyc - acc) > rsp_d);
  endfunction

  always @(posedge clk) begin
    rd_run = mem_rd ? rd_run + 1 : 0;
    if (reset) begin
      started = 1; txn = 0; last_rdata = 0;
    end else if (req_valid && model_ready()) begin
      int off;
      logic [31:0] w;
      off      = int'(req_addr[1:0]);
      e_addr   = req_addr & ~32'h3;
      w        = memrd(e_addr);
      e_err    = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && off != 0);
      rd_n = 0; wr_d = 0; e_wdata = 0; e_rdata = 0;
      if (e_err) rsp_d = 1;
      else if (!req_write) begin
        rd_n = LAT; rsp_d = LAT + 1; e_rdata = load_val(w, int'(req_size), req_sign, off);
      end else if (req_size == 2'd2) begin
        wr_d = 1; rsp_d = 2; e_wdata = req_wdata;
      end else begin
        rd_n = LAT; wr_d = LAT + 1; rsp_d = LAT + 2;
        e_wdata = store_val(w, int'(req_size), off, req_wdata);
      end
      prev_acc = acc; acc = cyc; txn = 1; acc_cnt++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      int d;
      bit e_rd, e_wr, e_rv;
      d    = cyc - acc;
      e_rd = txn && rd_n > 0 && d >= 1 && d <= rd_n;
      e_wr = txn && wr_d > 0 && d == wr_d;
      e_rv = txn && d == rsp_d;
      chk("req_ready", 32'(req_ready), 32'(model_ready()));
      chk("mem_rd", 32'(mem_rd), 32'(e_rd));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
      if (e_wr) begin
        chk("mem_wdata", mem_wdata, e_wdata);
        mem[e_addr] = e_wdata;
      end
      if (mem_wr) begin
        wr_cnt++; last_wr_data = mem_wdata; last_wr_addr = mem_addr; last_wr_d = d;
      end
      if (mem_rd) rd_cnt++;
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        last_rdata = e_rdata;
      end else chk("rsp_rdata_hold", rsp_rdata, last_rdata);
      if (rsp_valid) begin
        rsp_cnt++; last_rsp_rdata = rsp_rdata; last_rsp_err = rsp_err; last_rsp_d = d;
      end
      // memory data is only valid in the final cycle of the read window
      mem_rdata = (mem_rd && rd_run == LAT - 1) ? memrd(mem_addr) : 32'hBAD00BAD;
    end
  end

  // ---------------- driver ----------------
  task automatic scribble();
    req_write = 1'($urandom); req_size = 2'($urandom); req_sign = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic issue(input bit w, input int sz, input bit sg, input logic [31:0] a, input logic [31:0] wd);
    int n0, k;
    n0 = acc_cnt; k = 0;
    req_write = w; req_size = 2'(sz); req_sign = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (acc_cnt == n0 && k < 50) begin @(posedge clk); #1; k++; end
    if (acc_cnt == n0) chk("accept_timeout", 32'(k), 32'(0));
    req_valid = 1'b0;
    scribble();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!model_ready() && k < 50) begin @(posedge clk); #1; k++; end
    if (!model_ready()) chk("done_timeout", 32'(k), 32'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n_wr, n_rd, n_rsp, n_acc;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, n_rd, n_rsp, n_acc;
    reset = 1'b1;
    tick(3);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_strobes", {29'b0, mem_rd, mem_wr, rsp_valid}, 32'h0);
    reset = 1'b0;
    tick(1);

    // LW 0x100: three cycles to response, two read cycles
    mem[32'h100] = 32'hDEADBEEF;
    n_rd = rd_cnt;
    issue(0, 2, 0, 32'h100, 0); wait_done();
    chk("lw_rdata", last_rsp_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(last_rsp_err), 32'd0);
    chk("lw_rsp_cycle", 32'(last_rsp_d), 32'd3);
    chk("lw_rd_cycles", 32'(rd_cnt - n_rd), 32'd2);

    // sub-word load extraction
    mem[32'h100] = 32'h80FF1234;
    issue(0, 0, 1, 32'h103, 0); wait_done();
    chk("lb_sign", last_rsp_rdata, 32'hFFFFFF80);
    issue(0, 0, 0, 32'h103, 0); wait_done();
    chk("lb_zero", last_rsp_rdata, 32'h00000080);
    issue(0, 1, 1, 32'h102, 0); wait_done();
    chk("lh_sign", last_rsp_rdata, 32'hFFFF80FF);

    // SH read-modify-write: write at T+LAT+1, response at T+LAT+2
    mem[32'h100] = 32'h11223344;
    n_wr = wr_cnt;
    issue(1, 1, 0, 32'h102, 32'h0000ABCD); wait_done();
    chk("sh_wdata", last_wr_data, 32'hABCD3344);
    chk("sh_waddr", last_wr_addr, 32'h100);
    chk("sh_wr_cycle", 32'(last_wr_d), 32'd3);
    chk("sh_wr_count", 32'(wr_cnt - n_wr), 32'd1);
    chk("sh_rsp_cycle", 32'(last_rsp_d), 32'd4);

    // errors: no memory traffic, response next cycle
    n_wr = wr_cnt; n_rd = rd_cnt;
    issue(0, 2, 0, 32'h101, 0); wait_done();
    chk("lw_mis_err", 32'(last_rsp_err), 32'd1);
    chk("lw_mis_cycle", 32'(last_rsp_d), 32'd1);
    issue(1, 3, 0, 32'h200, 32'h55); wait_done();
    chk("sz3_err", 32'(last_rsp_err), 32'd1);
    chk("sz3_rdata", last_rsp_rdata, 32'h0);
    chk("err_no_mem", 32'(wr_cnt - n_wr + rd_cnt - n_rd), 32'd0);

    // reset during the read phase of an SB abandons it
    n_wr = wr_cnt; n_rsp = rsp_cnt;
    issue(1, 0, 0, 32'h105, 32'h77);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    tick(4);
    chk("rst_mid_no_wr", 32'(wr_cnt - n_wr), 32'd0);
    chk("rst_mid_no_rsp", 32'(rsp_cnt - n_rsp), 32'd0);
    issue(0, 2, 0, 32'h104, 0); wait_done();
    chk("post_rst_lw_cycle", 32'(last_rsp_d), 32'd3);
    chk("post_rst_lw_err", 32'(last_rsp_err), 32'd0);

    // reset wins over a simultaneous request
    n_acc = acc_cnt; n_rd = rd_cnt;
    req_write = 0; req_size = 2; req_addr = 32'h100; req_valid = 1'b1; reset = 1'b1;
    tick(1);
    req_valid = 1'b0; reset = 1'b0;
    chk("rst_prio_ready", 32'(req_ready), 32'd1);
    tick(3);
    chk("rst_prio_no_rd", 32'(rd_cnt - n_rd), 32'd0);
    n_acc = acc_cnt - n_acc;
    chk("rst_prio_no_acc", 32'(n_acc), 32'd0);

    // back-to-back word stores: second accepted in the IDLE cycle after RESP
    n_wr = wr_cnt;
    issue(1, 2, 0, 32'h120, 32'h1111);
    issue(1, 2, 0, 32'h124, 32'h2222);
    chk("b2b_gap", 32'(acc - prev_acc), 32'd3);
    wait_done();
    chk("b2b_wr_count", 32'(wr_cnt - n_wr), 32'd2);

    // random traffic over a small window so RMWs and loads overlap
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            32'h100 + $urandom_range(0, 63), $urandom);
      if ($urandom_range(0, 1) == 0) begin
        wait_done();
        tick(int'($urandom_range(0, 2)));
      end
    end
    wait_done();
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
